// File: rtl/dmem_responder.sv
// Word-organised data memory answering MEM-stage loads/stores over valid/ready
// request and response channels, with programmable wait states and error flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [4:0]            lane_shift;
    logic                  access_fire;
    logic                  req_err;
    logic                  wr_en;
    logic [3:0]            byte_en;
    logic [31:0]           wr_word;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;

    assign word_idx    = addr_q[ADDR_WIDTH+1:2];
    assign lane        = addr_q[1:0];
    assign lane_shift  = {lane, 3'b000};
    assign access_fire = (state_q == S_ACCESS) && (cnt_q == '0);

    // Any true condition rejects the request: no RAM side effect, zero data.
    always_comb begin
        req_err = 1'b0;
        if (size_q == 2'b11)                            req_err = 1'b1;
        if ((size_q == 2'b01) && addr_q[0])             req_err = 1'b1;
        if ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) req_err = 1'b1;
        if ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0)      req_err = 1'b1;
    end

    always_comb begin
        case (size_q)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
    end

    assign wr_word = wdata_q << lane_shift;
    assign wr_en   = access_fire && we_q && !req_err;

    // One byte-wide array per lane so untouched lanes need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && byte_en[gi]) begin
                    mem_lane[word_idx] <= wr_word[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem_lane[word_idx];
        end
    endgenerate

    assign rd_byte = rd_word[lane_shift +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_err || we_q) ? 32'd0 : load_data;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed spec scenarios plus random
// traffic checked against a byte-addressed memory model.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int WC    = 2;
    localparam int LAT   = WC + 1;
    localparam int NBYTE = 4 * (1 << AW);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] model_mem [NBYTE];

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rd;
        bit        exp_err;
    } op_t;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: byte-addressed memory, little-endian, plain arithmetic.
    function automatic void model_op(input bit we, input bit [1:0] size, input bit uns,
                                     input bit [31:0] addr, input bit [31:0] wdata,
                                     output bit [31:0] rd, output bit er);
        int nbytes;
        longint unsigned v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        er = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
             (size == 2'd2 && addr % 4 != 0) || (64'(addr) >= 64'(NBYTE));
        rd = 32'd0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nbytes; i++) model_mem[addr + i] = 8'((wdata >> (8 * i)) % 256);
        end else begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v = v + 64'(model_mem[addr + i]) * (64'd1 << (8 * i));
            if (!uns && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
                v = v + (64'd1 << 32) - (64'd1 << (8 * nbytes));
            rd = v[31:0];
        end
    endfunction

    task automatic issue(input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, output bit ok);
        int guard;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        ok = 1'b1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic do_req(input bit we, input bit [1:0] size, input bit uns,
                          input bit [31:0] addr, input bit [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic vld_after);
        bit ok;
        issue(we, size, uns, addr, wdata, ok);
        if (!ok) begin
            rd = 'x; er = 'x; lat = -1; vld_after = 'x;
            return;
        end
        wait_rsp(lat);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        vld_after = rsp_valid;
        $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 we, size, uns, addr, wdata, rd, er, lat);
    endtask

    task automatic test_reset;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h200;
        req_wdata = 32'hFFFFFFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: ready=%b valid=%b rdata=%08h err=%b required 0 0 00000000 0",
                         req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_spurious_rsp: valid=%b required 0", rsp_valid);
            end
        end
    endtask

    task automatic test_directed;
        op_t ops[$];
        logic [31:0] rd;
        logic er, va;
        int lat;
        bit [31:0] mrd;
        bit mer;
        ops.push_back('{1'b1, 2'd2, 1'b0, 32'h100,  32'hDEADBEEF, 32'h00000000, 1'b0});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
        ops.push_back('{1'b1, 2'd0, 1'b0, 32'h101,  32'h12345680, 32'h00000000, 1'b0});
        ops.push_back('{1'b0, 2'd0, 1'b0, 32'h101,  32'h0,        32'hFFFFFF80, 1'b0});
        ops.push_back('{1'b0, 2'd0, 1'b1, 32'h101,  32'h0,        32'h00000080, 1'b0});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0});
        ops.push_back('{1'b1, 2'd1, 1'b0, 32'h102,  32'hABCD1234, 32'h00000000, 1'b0});
        ops.push_back('{1'b0, 2'd1, 1'b0, 32'h102,  32'h0,        32'h00001234, 1'b0});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h100,  32'h0,        32'h123480EF, 1'b0});
        ops.push_back('{1'b1, 2'd1, 1'b0, 32'h103,  32'hFFFFFFFF, 32'h00000000, 1'b1});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h100,  32'h0,        32'h123480EF, 1'b0});
        ops.push_back('{1'b0, 2'd0, 1'b0, 32'h103,  32'h0,        32'h00000012, 1'b0});
        ops.push_back('{1'b1, 2'd1, 1'b0, 32'h100,  32'h00008001, 32'h00000000, 1'b0});
        ops.push_back('{1'b0, 2'd1, 1'b1, 32'h100,  32'h0,        32'h00008001, 1'b0});
        ops.push_back('{1'b0, 2'd1, 1'b0, 32'h100,  32'h0,        32'hFFFF8001, 1'b0});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h102,  32'h0,        32'h00000000, 1'b1});
        ops.push_back('{1'b0, 2'd3, 1'b0, 32'h100,  32'h0,        32'h00000000, 1'b1});
        ops.push_back('{1'b1, 2'd3, 1'b0, 32'h100,  32'h55555555, 32'h00000000, 1'b1});
        ops.push_back('{1'b1, 2'd2, 1'b0, 32'h1000, 32'h77777777, 32'h00000000, 1'b1});
        ops.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1});
        ops.push_back('{1'b0, 2'd2, 1'b1, 32'h100,  32'h0,        32'h12348001, 1'b0});
        ops.push_back('{1'b1, 2'd2, 1'b0, 32'hFFC,  32'hCAFEF00D, 32'h00000000, 1'b0});
        ops.push_back('{1'b0, 2'd1, 1'b0, 32'hFFE,  32'h0,        32'hFFFFCAFE, 1'b0});
        foreach (ops[i]) begin
            do_req(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, 0, rd, er, lat, va);
            model_op(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, mrd, mer);
            n_checks++;
            if (rd !== ops[i].exp_rd || er !== ops[i].exp_err || lat != LAT || va !== 1'b0) begin
                n_fail++;
                $display("FAIL directed[%0d]: rdata=%08h err=%b lat=%0d valid_after=%b required %08h %b %0d 0",
                         i, rd, er, lat, va, ops[i].exp_rd, ops[i].exp_err, LAT);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic er, va;
        int lat;
        bit [31:0] mrd, addr, wdata;
        bit mer, we, uns;
        bit [1:0] size;
        for (int w = 0; w < 64; w++) begin
            wdata = $urandom;
            do_req(1'b1, 2'd2, 1'b0, 32'(4 * w), wdata, 0, rd, er, lat, va);
            model_op(1'b1, 2'd2, 1'b0, 32'(4 * w), wdata, mrd, mer);
            n_checks++;
            if (rd !== mrd || er !== mer || lat != LAT || va !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_init[%0d]: rdata=%08h err=%b lat=%0d required %08h %b %0d",
                         w, rd, er, lat, mrd, mer, LAT);
            end
        end
        for (int n = 0; n < 250; n++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h1000;
            else                           addr = $urandom_range(0, 255);
            do_req(we, size, uns, addr, wdata, int'($urandom_range(0, 2)), rd, er, lat, va);
            model_op(we, size, uns, addr, wdata, mrd, mer);
            n_checks++;
            if (rd !== mrd || er !== mer || lat != LAT || va !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d]: rdata=%08h err=%b lat=%0d required %08h %b %0d",
                         n, rd, er, lat, mrd, mer, LAT);
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        int lat;
        logic [31:0] snap_rd, rd;
        logic snap_er, er, va;
        bit [31:0] mrd;
        bit mer;
        model_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, mrd, mer);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, ok);
        wait_rsp(lat);
        snap_rd = rsp_rdata;
        snap_er = rsp_err;
        n_checks++;
        if (!ok || snap_rd !== mrd || snap_er !== mer || lat != LAT) begin
            n_fail++;
            $display("FAIL stall_first: ok=%b rdata=%08h err=%b lat=%0d required 1 %08h %b %0d",
                     ok, snap_rd, snap_er, lat, mrd, mer, LAT);
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h100;
        req_wdata = 32'hAAAAAAAA;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== snap_rd || rsp_err !== snap_er || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b rdata=%08h err=%b ready=%b required 1 %08h %b 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, snap_rd, snap_er);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b required 0", rsp_valid);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd, er, lat, va);
        n_checks++;
        if (rd !== mrd || er !== 1'b0 || lat != LAT) begin
            n_fail++;
            $display("FAIL stall_ignored_store: rdata=%08h err=%b lat=%0d required %08h 0 %0d",
                     rd, er, lat, mrd, LAT);
        end
    endtask

    task automatic test_reset_midflight;
        bit ok;
        int lat;
        logic [31:0] rd;
        logic er, va;
        bit [31:0] mrd;
        bit mer;
        do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h0, 0, rd, er, lat, va);
        model_op(1'b1, 2'd2, 1'b0, 32'h200, 32'h0, mrd, mer);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h55, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (!ok || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access: ok=%b ready=%b valid=%b rdata=%08h err=%b required 1 0 0 00000000 0",
                     ok, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_access_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, rd, er, lat, va);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat != LAT) begin
            n_fail++;
            $display("FAIL rst_dropped_store: rdata=%08h err=%b lat=%0d required 00000000 0 %0d", rd, er, lat, LAT);
        end

        // Asynchronous reset while a response is pending must clear it without a clock edge.
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, ok);
        wait_rsp(lat);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (lat != LAT || rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_resp_async: lat=%0d valid=%b ready=%b rdata=%08h required %0d 0 0 00000000",
                     lat, rsp_valid, req_ready, rsp_rdata, LAT);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resp_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel.
- Owns a word-organised RAM.
- Byte-lane placement for stores; lane extraction plus sign/zero extension for loads.
- Programmable wait states.
- Flags misaligned, illegal-size and out-of-range accesses.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth 2^ADDR_WIDTH words, valid byte range 0 .. 4*2^ADDR_WIDTH-1
WAIT_CYCLES, 2, extra cycles spent in ACCESS before the array is touched (0 legal)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1=zero-extend (lbu/lhu), 0=sign-extend
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request was rejected (no side effect)

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - req_ready forced 0 while rst=1.
  - RAM contents are not reset.
- FSM states: IDLE, ACCESS, RESP. One outstanding request only.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch addr/we/size/unsigned/wdata, load counter=WAIT_CYCLES, go ACCESS.
- ACCESS:
  - req_ready=0.
  - Counter decrements each edge while nonzero.
  - On the edge where counter==0: perform access, load rsp_rdata/rsp_err, set rsp_valid=1, go RESP.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err held stable until rsp_valid&rsp_ready.
  - On that handshake edge: rsp_valid=0, go IDLE.
  - No request accepted in the handshake cycle; throughput is one request per WAIT_CYCLES+3 cycles minimum.
- Latency: accept at edge t0 gives rsp_valid=1 after edge t0+WAIT_CYCLES+1.
- Error check, evaluated on latched request; any true gives err=1, no RAM write, rdata=0:
  - size==11.
  - size==01 and addr[0]==1.
  - size==10 and addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2] != 0.
- Word index = addr[ADDR_WIDTH+1:2]; lane = addr[1:0].
- Store:
  - Byte writes wdata[7:0] into lane addr[1:0].
  - Half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}, little-endian.
  - Word writes all four lanes.
  - Untouched lanes are preserved (read-modify-write or per-lane enables; either is acceptable).
  - Store response: rdata=0, err=0.
- Load:
  - Extract the addressed byte/half/word, little-endian.
  - Extend to 32 bits per req_unsigned; req_unsigned is ignored for word loads.
- Reset in ACCESS: a store not yet committed is dropped, with no partial write. Reset in RESP: the response is discarded.
- Request inputs are ignored outside IDLE.

Test Plan:
1. Hold rst=1 with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Release -> req_ready=1 next cycle, no spurious response.
2. WAIT_CYCLES=2: sw 0xDEADBEEF @0x100, then lw @0x100 -> each rsp_valid rises 3 cycles after its accept edge, err=0; load rdata=0xDEADBEEF.
3. sb 0x80 @0x101 -> lb @0x101=0xFFFFFF80, lbu @0x101=0x00000080, lw @0x100=0xDEAD80EF.
4. sh 0x1234 @0x102 -> lh @0x102=0x00001234, lw @0x100=0x123480EF. Then sh 0x8001 @0x100 -> lhu @0x100=0x00008001, lh @0x100=0xFFFF8001.
5. Errors, all with err=1 and rdata=0:
   - lw @0x102.
   - sh @0x103, then lw @0x100 still 0x123480EF.
   - size=11.
   - sw @0x1000 with ADDR_WIDTH=10.
   - Each error still completes the full handshake.
6. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready=0, a new req_valid is ignored. Separately, pulse rst during ACCESS of sw 0x55 @0x200 (old 0) -> post-reset lw @0x200 returns 0.
